// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage and the condition
// evaluator (the evaluator is also reused by the ALU stage).
//   cond_e        : 3-bit branch/skip condition select from the decoder
//   fetch_state_e : fetch sequencer states
//   PC_STEP       : PC advance for one instruction word (bytes)
//   SKIP_STEP     : PC advance for a skip over the next instruction (bytes)
// ---------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_NEVER  = 3'd1,
    COND_Z      = 3'd2,
    COND_NZ     = 3'd3,
    COND_N      = 3'd4,
    COND_NN     = 3'd5,
    COND_C      = 3'd6,
    COND_NC     = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    PREF = 2'd2,
    ERR  = 2'd3
  } fetch_state_e;

  localparam int PC_STEP   = 2;
  localparam int SKIP_STEP = 4;

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition evaluator: decides whether the decoder's
// condition select holds for the current ALU flags.
// Ports:
//   cond      in  3  condition select (see fetch_pkg::cond_e)
//   flag_z    in  1  ALU zero flag
//   flag_n    in  1  ALU negative flag
//   flag_c    in  1  ALU carry flag
//   cond_true out 1  condition holds
// ---------------------------------------------------------------------------
module cond_eval
  import fetch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  input  logic       flag_c,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: cond_true = 1'b1;
      COND_NEVER:  cond_true = 1'b0;
      COND_Z:      cond_true = flag_z;
      COND_NZ:     cond_true = ~flag_z;
      COND_N:      cond_true = flag_n;
      COND_NN:     cond_true = ~flag_n;
      COND_C:      cond_true = flag_c;
      COND_NC:     cond_true = ~flag_c;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage in front of the microcoded decoder. Owns the PC and
// the instruction register, runs program-memory reads on IR_LOAD, applies
// branch / skip / increment PC updates, stalls the sequencer while a read is
// outstanding and raises a sticky bus error when memory never answers.
//
// Optional feature: define FETCH_PREFETCH_EN to add a one-entry prefetch
// buffer that speculatively reads the word after each completed fetch.
//
// Parameters:
//   ADDR_W   PC / memory address width
//   RESET_PC PC value after reset
//   TIMEOUT  unanswered request cycles before bus_err is raised (>= 1)
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous active-low reset
//   ir_load    in   1       start fetch at current PC (ignored while busy)
//   incr_pc    in   1       PC += 2
//   be         in   1       branch request
//   cond_chk   in   1       evaluate cond against flags
//   cond       in   3       condition select
//   flag_z/n/c in   1       ALU flags
//   br_target  in   ADDR_W  branch target (bit 0 is dropped)
//   mem_req    out  1       program memory read request
//   mem_addr   out  ADDR_W  read address, captured when the request starts
//   mem_rdata  in   16      read data, valid with mem_ack
//   mem_ack    in   1       read complete
//   instr      out  16      instruction register
//   pc         out  ADDR_W  program counter
//   stall      out  1       hold decoder sequencer
//   bus_err    out  1       sticky fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_load,
  input  logic              incr_pc,
  input  logic              be,
  input  logic              cond_chk,
  input  logic [2:0]        cond,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_c,
  input  logic [ADDR_W-1:0] br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic              bus_err
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] SKIP     = ADDR_W'(SKIP_STEP);

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [15:0]       instr_nxt;
  logic              mem_req_nxt;
  logic              stall_nxt;
  logic              bus_err_nxt;
  logic [CNT_W-1:0]  tmo_cnt, cnt_nxt;

  logic cond_true;
  logic take_branch;
  logic take_skip;
  logic tmo_hit;
  logic do_fetch;
  logic go_err;

`ifdef FETCH_PREFETCH_EN
  logic              pf_valid, pf_valid_nxt;
  logic [ADDR_W-1:0] pf_addr, pf_addr_nxt;
  logic [15:0]       pf_data, pf_data_nxt;
  // An ack for a prefetch that a branch/skip has overtaken must be dropped.
  logic              pf_discard, pf_discard_nxt;
  // IR_LOAD arrived while the prefetch was in flight; resolve it on the ack.
  logic              pf_pend, pf_pend_nxt;
  logic              pc_redirect;
  logic              do_pref;
  logic [ADDR_W-1:0] pref_base;
`endif

  cond_eval u_cond_eval (
    .cond      (cond),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .cond_true (cond_true)
  );

  assign take_branch = be & (~cond_chk | cond_true);
  assign take_skip   = cond_chk & ~be & cond_true;
  assign tmo_hit     = (tmo_cnt == CNT_LAST);

  // PC update: branch beats skip beats increment; an increment in the same
  // cycle as a redirect is absorbed. Adds wrap modulo 2^ADDR_W.
  always_comb begin
    pc_nxt = pc;
    if (take_branch) begin
      pc_nxt = br_target & ~(ADDR_W'(1));
    end else if (take_skip) begin
      pc_nxt = pc + SKIP;
    end else if (incr_pc) begin
      pc_nxt = pc + STEP;
    end
  end

  // Fetch sequencer next-state. The case body only decides what happens;
  // the shared "start a read" / "give up" actions are applied afterwards so
  // that every path that starts a request sets the same registers.
  // IR_LOAD in ERR behaves like IDLE: it leaves the error state and starts
  // a fresh fetch in the same step, while bus_err stays latched.
  always_comb begin
    state_nxt    = state;
    instr_nxt    = instr;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    stall_nxt    = stall;
    bus_err_nxt  = bus_err;
    cnt_nxt      = tmo_cnt;
    do_fetch     = 1'b0;
    go_err       = 1'b0;
`ifdef FETCH_PREFETCH_EN
    pf_valid_nxt   = pf_valid;
    pf_addr_nxt    = pf_addr;
    pf_data_nxt    = pf_data;
    pf_discard_nxt = pf_discard;
    pf_pend_nxt    = pf_pend;
    pc_redirect    = take_branch | take_skip;
    do_pref        = 1'b0;
    pref_base      = '0;
`endif

    case (state)
      IDLE, ERR: begin
        if (ir_load) begin
`ifdef FETCH_PREFETCH_EN
          if (pf_valid && (pf_addr == pc)) begin
            instr_nxt = pf_data;
            stall_nxt = 1'b0;
            do_pref   = 1'b1;
            pref_base = pf_addr;
          end else begin
            do_fetch = 1'b1;
          end
`else
          do_fetch = 1'b1;
`endif
        end
      end

      REQ: begin
        if (mem_ack) begin
          instr_nxt   = mem_rdata;
          mem_req_nxt = 1'b0;
          stall_nxt   = 1'b0;
          state_nxt   = IDLE;
`ifdef FETCH_PREFETCH_EN
          do_pref   = 1'b1;
          pref_base = mem_addr;
`endif
        end else begin
          cnt_nxt = tmo_cnt + CNT_W'(1);
          go_err  = tmo_hit;
        end
      end

`ifdef FETCH_PREFETCH_EN
      PREF: begin
        if (ir_load) begin
          pf_pend_nxt = 1'b1;
          stall_nxt   = 1'b1;
        end
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
          pf_pend_nxt = 1'b0;
          if (pf_pend || ir_load) begin
            if (!pf_discard && (pf_addr == pc)) begin
              instr_nxt = mem_rdata;
              stall_nxt = 1'b0;
              do_pref   = 1'b1;
              pref_base = pf_addr;
            end else begin
              do_fetch = 1'b1;
            end
          end else begin
            pf_valid_nxt = ~pf_discard;
            pf_data_nxt  = mem_rdata;
          end
        end else begin
          cnt_nxt = tmo_cnt + CNT_W'(1);
          go_err  = tmo_hit;
        end
      end
`else
      PREF: state_nxt = IDLE;
`endif

      default: state_nxt = IDLE;
    endcase

    if (go_err) begin
      state_nxt   = ERR;
      bus_err_nxt = 1'b1;
      mem_req_nxt = 1'b0;
      stall_nxt   = 1'b0;
      instr_nxt   = 16'h0000;
`ifdef FETCH_PREFETCH_EN
      pf_valid_nxt = 1'b0;
      pf_pend_nxt  = 1'b0;
`endif
    end

    if (do_fetch) begin
      state_nxt    = REQ;
      mem_req_nxt  = 1'b1;
      mem_addr_nxt = pc;
      stall_nxt    = 1'b1;
      cnt_nxt      = '0;
    end

`ifdef FETCH_PREFETCH_EN
    if (do_pref) begin
      state_nxt      = PREF;
      mem_req_nxt    = 1'b1;
      mem_addr_nxt   = pref_base + STEP;
      pf_addr_nxt    = pref_base + STEP;
      pf_valid_nxt   = 1'b0;
      pf_discard_nxt = 1'b0;
      pf_pend_nxt    = 1'b0;
      cnt_nxt        = '0;
    end

    // A branch or skip makes the buffered/in-flight word stale.
    if (pc_redirect) begin
      pf_valid_nxt = 1'b0;
      if (state_nxt == PREF) begin
        pf_discard_nxt = 1'b1;
      end
    end
`endif
  end

  // State register; reset drops mem_req immediately so an in-flight read
  // is abandoned and its late ack lands in IDLE where it is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= 16'h0000;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      stall    <= 1'b0;
      bus_err  <= 1'b0;
      tmo_cnt  <= '0;
`ifdef FETCH_PREFETCH_EN
      pf_valid   <= 1'b0;
      pf_addr    <= '0;
      pf_data    <= 16'h0000;
      pf_discard <= 1'b0;
      pf_pend    <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      instr    <= instr_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
      stall    <= stall_nxt;
      bus_err  <= bus_err_nxt;
      tmo_cnt  <= cnt_nxt;
`ifdef FETCH_PREFETCH_EN
      pf_valid   <= pf_valid_nxt;
      pf_addr    <= pf_addr_nxt;
      pf_data    <= pf_data_nxt;
      pf_discard <= pf_discard_nxt;
      pf_pend    <= pf_pend_nxt;
`endif
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the microcoded decoder.
- Owns the PC and the instruction register (IR).
- Runs the word read from program memory when the decoder asserts IR load, presents `instr` to the decoder, and applies PC increment, skip and branch updates driven by decoder control strobes and ALU flags.
- Stalls the sequencer while memory wait states are outstanding.

Parameters:
- RESET_PC, 16'h0000, PC value after reset.
- ADDR_W, 16, PC/memory address width.
- TIMEOUT, 255, mem_ack wait cycles before the bus error flag is raised.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- ir_load  in  1  decoder IR_LOAD strobe: start fetch at current PC
- incr_pc  in  1  decoder INCR_PC strobe: PC += 2
- be  in  1  decoder BE strobe: branch request
- cond_chk  in  1  decoder COND_CHK: evaluate cond against flags
- cond  in  3  condition select from decoder
- flag_z, flag_n, flag_c  in  1 each  ALU zero/negative/carry flags
- br_target  in  ADDR_W  branch target (ALU result)
- mem_req  out  1  read request to program memory
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  read complete
- instr  out  16  IR contents to decoder
- pc  out  ADDR_W  current PC
- stall  out  1  hold decoder sequencer
- bus_err  out  1  sticky fetch timeout flag

Behaviour:
- Reset (async, reset=0) values: pc=RESET_PC, instr=16'h0000, mem_req=0, mem_addr=0, stall=0, bus_err=0, FSM=IDLE, timeout counter=0.
- FSM states:
  - IDLE: on ir_load go to REQ; mem_addr<=pc; mem_req<=1; stall<=1.
  - REQ: mem_req held high. On mem_ack, go to IDLE: instr<=mem_rdata, mem_req<=0, stall<=0. Fetch latency is 1 cycle when mem_ack arrives the cycle after the request.
  - Counter: counts each REQ cycle without mem_ack. On reaching TIMEOUT go to ERR.
  - ERR: bus_err=1; mem_req=0; stall=0; instr<=16'h0000 (zero instruction). Return to IDLE on the next ir_load. bus_err stays set until reset.
- ir_load while not IDLE: ignored.
- Condition encoding `cond_true(cond)`:
  - 0 always
  - 1 never
  - 2 Z
  - 3 !Z
  - 4 N
  - 5 !N
  - 6 C
  - 7 !C
- PC update priority, evaluated each cycle:
  1. be & (!cond_chk | cond_true): pc<=br_target & ~1 (bit0 forced 0).
  2. cond_chk & !be & cond_true: skip, pc<=pc+4.
  3. incr_pc: pc<=pc+2.
  4. Otherwise hold.
- Rules 1 and 2 are each taken at most once per strobe cycle. incr_pc in the same cycle as a taken branch or skip is absorbed.
- PC arithmetic is modulo 2^ADDR_W. 16'hFFFE+2 wraps to 16'h0000; 16'hFFFE+4 wraps to 16'h0002.
- PC updates during REQ are legal. mem_addr is captured at request time, so the in-flight fetch is unaffected.
- Reset asserted mid-fetch: mem_req drops immediately (async). A late mem_ack is ignored.

Optional Feature:
- Macro FETCH_PREFETCH_EN.
- Defined:
  - Adds a one-entry prefetch buffer (pf_valid, pf_addr, pf_data).
  - After each completed fetch, the FSM issues a speculative read of pc+2 (state PREF).
  - A later ir_load with pf_valid and pf_addr==pc loads instr from the buffer in 1 cycle with stall=0.
  - Any taken branch or skip clears pf_valid. If PREF is in flight, its ack is discarded.
  - ir_load during PREF waits for that ack.
- Undefined: no buffer; every ir_load performs a memory read.

Decomposition:
- Package fetch_pkg holds:
  - cond encodings COND_ALWAYS..COND_NC
  - FSM state enum {IDLE, REQ, PREF, ERR}
  - PC step constants (2, 4)
- One natural sub-module: cond_eval (combinational cond/flags -> cond_true), reusable by the ALU stage.

Test Plan:
- Reset release, ir_load, mem_ack next cycle with rdata=16'hA5C3 -> instr=16'hA5C3 one cycle after ack, stall high exactly 1 cycle, mem_addr=0.
- pc=16'h0010, incr_pc pulse x3 -> pc=16'h0016. Then be=1, cond_chk=0, br_target=16'h1235 -> pc=16'h1234.
- cond_chk=1, cond=2, flag_z=1 -> pc+4. Same with flag_z=0 -> pc unchanged. cond=1 with be=1 -> no branch.
- pc=16'hFFFE, incr_pc -> 16'h0000. pc=16'hFFFE, taken skip -> 16'h0002.
- ir_load with mem_ack withheld TIMEOUT cycles -> bus_err=1, instr=0, stall=0. Later ir_load with ack -> normal fetch, bus_err remains 1.
- FETCH_PREFETCH_EN: fetch at 0, ack; next ir_load at pc=2 -> stall stays 0, instr=word@2. Branch to 16'h0040 -> buffer flushed, next ir_load performs a memory read at 16'h0040.
